// File: rtl/zebra_detection_filter_if.sv
`default_nettype none
// ============================================================================
// Module   : zebra_detection_filter_if
// Brief    : Frame-result input bundle and filtered-decision outputs.
// Revision : 1.0
// ============================================================================
interface zebra_detection_filter_if #(
   parameter int WINDOW = 8
);
   localparam int HIT_W = $clog2(WINDOW + 1);

   logic             detection_valid;
   logic             zebra_detected;
   logic [7:0]       blob_count;

   logic             crossing_active;
   logic             crossing_rise;
   logic             crossing_fall;
   logic [HIT_W-1:0] hit_count;
   logic [1:0]       state;
   logic             stale;
   logic [15:0]      frame_total;
   logic [15:0]      event_total;

   modport master (
      output detection_valid, zebra_detected, blob_count,
      input  crossing_active, crossing_rise, crossing_fall, hit_count,
             state, stale, frame_total, event_total
   );

   modport slave (
      input  detection_valid, zebra_detected, blob_count,
      output crossing_active, crossing_rise, crossing_fall, hit_count,
             state, stale, frame_total, event_total
   );
endinterface
`default_nettype wire

// File: rtl/zebra_detection_filter.sv
`default_nettype none
// ============================================================================
// Module   : zebra_detection_filter
// Brief    : N-of-WINDOW vote, hysteresis and hold-off on per-frame zebra
//            results, with stalled-stream watchdog. Macro ZEBRA_STATS_EN
//            enables the frame/event statistics counters.
// Revision : 1.0
// ============================================================================
module zebra_detection_filter #(
   parameter int WINDOW         = 8,
   parameter int ENTER_HITS     = 5,
   parameter int EXIT_HITS      = 2,
   parameter int HOLD_FRAMES    = 3,
   parameter int MIN_BLOBS      = 3,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   zebra_detection_filter_if.slave  bus
);
   localparam int CW = $clog2(WINDOW + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] c_idle   = 2'd0;
   localparam logic [1:0] c_armed  = 2'd1;
   localparam logic [1:0] c_active = 2'd2;
   localparam logic [1:0] c_hold   = 2'd3;

   localparam logic [CW-1:0] c_enter_hits  = CW'(ENTER_HITS);
   localparam logic [CW-1:0] c_exit_hits   = CW'(EXIT_HITS);
   localparam logic [7:0]    c_hold_frames = 8'(HOLD_FRAMES);
   localparam logic [7:0]    c_min_blobs   = 8'(MIN_BLOBS);
   localparam logic [TW-1:0] c_timeout     = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] c_timeout_m1  = TW'(TIMEOUT_CYCLES - 1);

   logic [WINDOW-1:0] r_hist;
   logic [CW-1:0]     r_hit_count;
   logic [1:0]        r_state;
   logic [7:0]        r_hold;
   logic [TW-1:0]     r_wd;
   logic              r_stale;
   logic              r_active;
   logic              r_rise;
   logic              r_fall;

   logic              w_hit;
   logic              w_oldest;
   logic [WINDOW-1:0] w_hist_shift;
   logic [CW-1:0]     w_hit_next;

   logic [WINDOW-1:0] w_hist_n;
   logic [CW-1:0]     w_hit_count_n;
   logic [1:0]        w_state_n;
   logic [7:0]        w_hold_n;
   logic [TW-1:0]     w_wd_n;
   logic              w_stale_n;
   logic              w_rise_n;
   logic              w_fall_n;

   assign w_hit      = bus.zebra_detected && (bus.blob_count >= c_min_blobs);
   assign w_oldest   = r_hist[WINDOW-1];
   // Running count: add the incoming bit, drop the one leaving the window.
   assign w_hit_next = r_hit_count + CW'(w_hit) - CW'(w_oldest);

   generate
      if (WINDOW == 1) begin : g_hist_single
         assign w_hist_shift = w_hit;
      end else begin : g_hist_shift
         assign w_hist_shift = {r_hist[WINDOW-2:0], w_hit};
      end
   endgenerate

   always_comb begin
      w_hist_n      = r_hist;
      w_hit_count_n = r_hit_count;
      w_state_n     = r_state;
      w_hold_n      = r_hold;
      w_wd_n        = r_wd;
      w_stale_n     = r_stale;
      w_rise_n      = 1'b0;
      w_fall_n      = 1'b0;

      if (bus.detection_valid) begin
         w_wd_n        = '0;
         w_stale_n     = 1'b0;
         w_hist_n      = w_hist_shift;
         w_hit_count_n = w_hit_next;
         case (r_state)
            c_idle: begin
               if (w_hit) begin
                  w_state_n = c_armed;
               end
            end
            c_armed: begin
               if (w_hit_next >= c_enter_hits) begin
                  w_state_n = c_active;
                  w_rise_n  = 1'b1;
               end else if (w_hit_next == '0) begin
                  w_state_n = c_idle;
               end
            end
            c_active: begin
               if (w_hit_next <= c_exit_hits) begin
                  w_state_n = c_hold;
                  w_hold_n  = 8'd1;
               end
            end
            default: begin
               // r_hold counts low frames seen in HOLD, offset by one from entry.
               if (w_hit_next > c_exit_hits) begin
                  w_state_n = c_active;
                  w_hold_n  = '0;
               end else if (r_hold >= c_hold_frames) begin
                  w_state_n = c_idle;
                  w_hold_n  = '0;
                  w_fall_n  = 1'b1;
               end else begin
                  w_hold_n  = r_hold + 8'd1;
               end
            end
         endcase
      end else if (r_wd != c_timeout) begin
         w_wd_n = r_wd + TW'(1);
         if (r_wd == c_timeout_m1) begin
            w_stale_n     = 1'b1;
            w_hist_n      = '0;
            w_hit_count_n = '0;
            w_state_n     = c_idle;
            w_hold_n      = '0;
            w_fall_n      = (r_state == c_active) || (r_state == c_hold);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hist      <= '0;
         r_hit_count <= '0;
         r_state     <= c_idle;
         r_hold      <= '0;
         r_wd        <= '0;
         r_stale     <= 1'b0;
         r_active    <= 1'b0;
         r_rise      <= 1'b0;
         r_fall      <= 1'b0;
      end else begin
         r_hist      <= w_hist_n;
         r_hit_count <= w_hit_count_n;
         r_state     <= w_state_n;
         r_hold      <= w_hold_n;
         r_wd        <= w_wd_n;
         r_stale     <= w_stale_n;
         r_active    <= (w_state_n == c_active) || (w_state_n == c_hold);
         r_rise      <= w_rise_n;
         r_fall      <= w_fall_n;
      end
   end

   assign bus.crossing_active = r_active;
   assign bus.crossing_rise   = r_rise;
   assign bus.crossing_fall   = r_fall;
   assign bus.hit_count       = r_hit_count;
   assign bus.state           = r_state;
   assign bus.stale           = r_stale;

`ifdef ZEBRA_STATS_EN
   logic [15:0] r_frame_total;
   logic [15:0] r_event_total;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_total <= '0;
         r_event_total <= '0;
      end else begin
         if (bus.detection_valid && (r_frame_total != 16'hFFFF)) begin
            r_frame_total <= r_frame_total + 16'd1;
         end
         if (w_rise_n && (r_event_total != 16'hFFFF)) begin
            r_event_total <= r_event_total + 16'd1;
         end
      end
   end

   assign bus.frame_total = r_frame_total;
   assign bus.event_total = r_event_total;
`else
   assign bus.frame_total = '0;
   assign bus.event_total = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_zebra_detection_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_zebra_detection_filter
// Brief    : Directed and random frame streams against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_zebra_detection_filter;
   localparam int WINDOW = 8;
   localparam int ENTER  = 5;
   localparam int EXIT   = 2;
   localparam int HOLDF  = 3;
   localparam int MINB   = 3;
   localparam int TO     = 1000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   zebra_detection_filter_if #(.WINDOW(WINDOW)) bus ();

   zebra_detection_filter #(
      .WINDOW(WINDOW), .ENTER_HITS(ENTER), .EXIT_HITS(EXIT),
      .HOLD_FRAMES(HOLDF), .MIN_BLOBS(MINB), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: window kept as a queue of hit bits, count by summation.
   bit m_hist[$];
   int m_state, m_low, m_wd, m_frames, m_events;
   bit m_stale, m_rise, m_fall;

   function automatic int m_count();
      int s = 0;
      foreach (m_hist[i]) s += int'(m_hist[i]);
      return s;
   endfunction

   function automatic void m_clear_hist();
      m_hist = {};
      for (int i = 0; i < WINDOW; i++) m_hist.push_back(1'b0);
   endfunction

   function automatic void model_reset();
      m_clear_hist();
      m_state = 0; m_low = 0; m_wd = 0; m_frames = 0; m_events = 0;
      m_stale = 0; m_rise = 0; m_fall = 0;
   endfunction

   function automatic void model_step(bit v, bit z, int b);
      bit hit;
      int cnt;
      m_rise = 0;
      m_fall = 0;
      if (v) begin
         hit = z && (b >= MINB);
         m_wd = 0;
         m_stale = 0;
         if (m_frames < 65535) m_frames++;
         m_hist.push_back(hit);
         void'(m_hist.pop_front());
         cnt = m_count();
         case (m_state)
            0: if (hit) m_state = 1;
            1: begin
               if (cnt >= ENTER) begin
                  m_state = 2; m_rise = 1;
                  if (m_events < 65535) m_events++;
               end else if (cnt == 0) m_state = 0;
            end
            2: if (cnt <= EXIT) begin m_state = 3; m_low = 0; end
            default: begin
               if (cnt > EXIT) m_state = 2;
               else begin
                  m_low++;
                  if (m_low == HOLDF) begin m_state = 0; m_fall = 1; end
               end
            end
         endcase
      end else if (m_wd < TO) begin
         m_wd++;
         if (m_wd == TO) begin
            m_stale = 1;
            m_clear_hist();
            if (m_state >= 2) m_fall = 1;
            m_state = 0;
         end
      end
   endfunction

   task automatic check_outputs();
      check("state",  32'(bus.state),           32'(m_state));
      check("hit_count", 32'(bus.hit_count),    32'(m_count()));
      check("active", 32'(bus.crossing_active), 32'(m_state >= 2));
      check("rise",   32'(bus.crossing_rise),   32'(m_rise));
      check("fall",   32'(bus.crossing_fall),   32'(m_fall));
      check("stale",  32'(bus.stale),           32'(m_stale));
      check("rise_fall_excl", 32'(bus.crossing_rise & bus.crossing_fall), 32'd0);
`ifdef ZEBRA_STATS_EN
      check("frame_total", 32'(bus.frame_total), 32'(m_frames));
      check("event_total", 32'(bus.event_total), 32'(m_events));
`else
      check("frame_total", 32'(bus.frame_total), 32'd0);
      check("event_total", 32'(bus.event_total), 32'd0);
`endif
   endtask

   task automatic cycle(input bit v, input bit z, input int b);
      @(negedge clk);
      bus.detection_valid = v;
      bus.zebra_detected  = z;
      bus.blob_count      = 8'(b);
      @(posedge clk);
      model_step(v, z, b);
      #1;
      check_outputs();
   endtask

   // Idle cycles carry junk on the data lines; it must be ignored.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'($urandom), int'($urandom_range(0, 255)));
   endtask

   task automatic frame(input bit z, input int b, input int gap);
      cycle(1'b1, z, b);
      idle(gap);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bus.detection_valid = 1'b0;
      bus.zebra_detected  = 1'b0;
      bus.blob_count      = 8'd0;
      model_reset();
      #3;
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;

      // Entry: five hits 100 cycles apart.
      for (int i = 0; i < 5; i++) frame(1'b1, 4, 99);
      check("entry_state", 32'(bus.state), 32'd2);
      // Release: misses until HOLD, then three low frames in HOLD.
      for (int i = 0; i < 9; i++) frame(1'b0, 0, 3);
      check("release_state", 32'(bus.state), 32'd0);

      // HOLD re-entry into ACTIVE.
      for (int i = 0; i < 5; i++) frame(1'b1, 5, 2);
      for (int i = 0; i < 6; i++) frame(1'b0, 7, 2);
      check("hold_state", 32'(bus.state), 32'd3);
      for (int i = 0; i < 3; i++) frame(1'b1, 3, 1);

      // Too few blobs is not a hit.
      do_reset();
      for (int i = 0; i < 6; i++) frame(1'b1, 2, 1);
      frame(1'b0, 200, 1);
      check("low_blob_count", 32'(bus.hit_count), 32'd0);

      // Watchdog expiry while ACTIVE, then recovery frame.
      do_reset();
      for (int i = 0; i < 5; i++) frame(1'b1, 4, 0);
      idle(TO);
      check("stale_set", 32'(bus.stale), 32'd1);
      idle(20);
      frame(1'b1, 4, 2);
      check("stale_clear", 32'(bus.stale), 32'd0);

      // Frame arriving on the exact timeout cycle wins.
      frame(1'b1, 4, TO - 1);
      frame(1'b1, 4, TO - 2);
      frame(1'b0, 0, 0);

      // Random stream, occasional long stall.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 799) == 0) idle(TO + 5);
         else if ($urandom_range(0, 99) < 35)
            cycle(1'b1, ($urandom_range(0, 99) < 65), int'($urandom_range(0, 6)));
         else idle(1);
      end

      // Asynchronous reset mid-hold.
      do_reset();
      for (int i = 0; i < 5; i++) frame(1'b1, 4, 1);
      for (int i = 0; i < 7; i++) frame(1'b0, 0, 1);
      check("mid_hold_state", 32'(bus.state), 32'd3);
      do_reset();
      idle(2);

      // Ten frames with one confirmed entry.
      for (int i = 0; i < 5; i++) frame(1'b1, 4, 1);
      for (int i = 0; i < 5; i++) frame(1'b0, 0, 1);
`ifdef ZEBRA_STATS_EN
      check("stats_frames_10", 32'(bus.frame_total), 32'd10);
      check("stats_events_1",  32'(bus.event_total), 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
